// File: rtl/mpu_common_pkg.sv
// Shared TileLink-UL channel types and helpers used by the MPU interconnect blocks.
package mpu_common;

  localparam int unsigned CORE_ID_WIDTH = 4;
  localparam int unsigned TL_AW         = 32;
  localparam int unsigned TL_DW         = 32;
  localparam int unsigned TL_MW         = TL_DW / 8;

  typedef struct packed {
    logic                     valid;
    logic [2:0]               opcode;
    logic [2:0]               param;
    logic [2:0]               size;
    logic [CORE_ID_WIDTH-1:0] source;
    logic [TL_AW-1:0]         address;
    logic [TL_MW-1:0]         mask;
    logic [TL_DW-1:0]         data;
  } tl_a_channel;

  typedef struct packed {
    logic [2:0]               opcode;
    logic [1:0]               param;
    logic [2:0]               size;
    logic [CORE_ID_WIDTH-1:0] source;
    logic                     denied;
    logic [TL_DW-1:0]         data;
    logic                     corrupt;
  } tl_d_channel;

  // Encode a one-hot vector (up to 16 entries) into a core index.
  function automatic logic [CORE_ID_WIDTH-1:0] onehot_to_id(input logic [15:0] oh);
    logic [CORE_ID_WIDTH-1:0] id;
    id = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) id = id | CORE_ID_WIDTH'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/arb_age_pick.sv
// Oldest-first selector: grants the eligible requester with the largest age,
// lowest index on ties.
module arb_age_pick #(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned AgeWidth = 8
) (
  input  logic [NumReq-1:0]               elig_i,
  input  logic [NumReq-1:0][AgeWidth-1:0] age_i,
  output logic [NumReq-1:0]               gnt_o
);

  logic [AgeWidth-1:0] best_age;
  logic                found;

  // Strict '>' keeps the earlier (lower) index on equal ages.
  always_comb begin
    gnt_o    = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (elig_i[i] && (!found || (age_i[i] > best_age))) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        best_age = age_i[i];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tl_arb_v2.sv
// Age-based TileLink-UL A-channel arbiter with per-core outstanding limits and
// a D-channel response demux back to the cores.
module tl_arb_v2
  import mpu_common::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned AGE_WIDTH = 8,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  tl_a_channel          req [NUM_CORES],
  output logic [NUM_CORES-1:0] ack,
  output tl_a_channel          win_req,
  input  logic                 a_ready,
  input  logic                 d_valid,
  input  tl_d_channel          resp,
  output logic                 d_ready,
  output tl_d_channel          c_resp [NUM_CORES],
  output logic [NUM_CORES-1:0] c_valid,
  input  logic [NUM_CORES-1:0] c_ready,
  output logic                 src_err
);

  localparam int unsigned OutstWidth = $clog2(MAX_OUTST + 1);

  tl_a_channel                         win_q, win_d;
  logic [AGE_WIDTH-1:0]                age_q   [NUM_CORES];
  logic [AGE_WIDTH-1:0]                age_d   [NUM_CORES];
  logic [OutstWidth-1:0]               outst_q [NUM_CORES];
  logic [OutstWidth-1:0]               outst_d [NUM_CORES];
  logic                                src_err_q, src_err_d;

  logic                                stage_free;
  logic                                src_ok;
  logic [NUM_CORES-1:0]                cand;
  logic [NUM_CORES-1:0]                gnt;
  logic [NUM_CORES-1:0]                d_done;
  logic [NUM_CORES-1:0][AGE_WIDTH-1:0] age_vec;

  // The slot is free when empty or when its current occupant leaves this cycle.
  assign stage_free = !win_q.valid || a_ready;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      cand[i]    = stage_free && req[i].valid && (outst_q[i] < OutstWidth'(MAX_OUTST));
      age_vec[i] = age_q[i];
    end
  end

  arb_age_pick #(
    .NumReq   (NUM_CORES),
    .AgeWidth (AGE_WIDTH)
  ) u_pick (
    .elig_i (cand),
    .age_i  (age_vec),
    .gnt_o  (gnt)
  );

  assign ack = gnt & {NUM_CORES{~rst}};

  // Response demux; unmatched sources fall through with d_ready=1 and are dropped.
  assign src_ok = 32'(resp.source) < NUM_CORES;

  always_comb begin
    d_ready = 1'b1;
    c_valid = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      c_resp[i] = resp;
      if (resp.source == CORE_ID_WIDTH'(i)) begin
        c_valid[i] = d_valid;
        d_ready    = c_ready[i];
      end
    end
  end

  assign d_done = c_valid & c_ready;

  always_comb begin
    win_d = win_q;
    if (|gnt) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (gnt[i]) win_d = req[i];
      end
      win_d.source = onehot_to_id(16'(gnt));
    end else if (a_ready) begin
      win_d.valid = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!req[i].valid || gnt[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != {AGE_WIDTH{1'b1}}) begin
        age_d[i] = age_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i];
      end

      // Simultaneous issue and completion cancel out; completions never underflow.
      outst_d[i] = outst_q[i];
      if (gnt[i] && !d_done[i]) begin
        outst_d[i] = outst_q[i] + 1'b1;
      end else if (!gnt[i] && d_done[i] && (outst_q[i] != '0)) begin
        outst_d[i] = outst_q[i] - 1'b1;
      end
    end
  end

  assign src_err_d = src_err_q | (d_valid & ~src_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      src_err_q <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        age_q[i]   <= '0;
        outst_q[i] <= '0;
      end
    end else begin
      win_q     <= win_d;
      src_err_q <= src_err_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        age_q[i]   <= age_d[i];
        outst_q[i] <= outst_d[i];
      end
    end
  end

  assign win_req = win_q;
  assign src_err = src_err_q;

endmodule

// File: tb/tb_tl_arb_v2.sv
// Self-checking bench for tl_arb_v2: demux vector table plus grant/aging/limit/reset sequences.
module tb_tl_arb_v2;
  import mpu_common::*;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  tl_a_channel    req [N];
  logic [N-1:0]   ack;
  tl_a_channel    win_req;
  logic           a_ready;
  logic           d_valid;
  tl_d_channel    resp;
  logic           d_ready;
  tl_d_channel    c_resp [N];
  logic [N-1:0]   c_valid;
  logic [N-1:0]   c_ready;
  logic           src_err;

  int checks = 0;
  int errors = 0;
  tl_a_channel exp_q [$];

  typedef struct {
    logic [3:0] src;
    logic       dv;
    logic [3:0] cr;
    logic [3:0] exp_cv;
    logic       exp_dr;
    logic       exp_err;
  } dmx_vec_t;

  dmx_vec_t tbl [7];

  always #5 clk = ~clk;

  tl_arb_v2 #(
    .NUM_CORES (N),
    .AGE_WIDTH (8),
    .MAX_OUTST (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .win_req (win_req),
    .a_ready (a_ready),
    .d_valid (d_valid),
    .resp    (resp),
    .d_ready (d_ready),
    .c_resp  (c_resp),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .src_err (src_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic tl_a_channel mkreq(input logic [2:0] op, input logic [31:0] addr);
    tl_a_channel r;
    r         = '0;
    r.valid   = 1'b1;
    r.opcode  = op;
    r.param   = 3'd1;
    r.size    = 3'd2;
    r.source  = 4'hf;
    r.address = addr;
    r.mask    = 4'hf;
    r.data    = addr ^ 32'h5a5a_0000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: checks ack, retires accepted win_req against the
  // scoreboard, then records expected captures for this cycle's grants.
  task automatic step(input string name, input logic [N-1:0] exp_ack);
    tl_a_channel e;
    #4;
    check({name, "_ack"}, 32'(ack), 32'(exp_ack));
    if (win_req.valid && a_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_sb: got win_req %h expected none", name, win_req);
      end else begin
        e = exp_q.pop_front();
        if (win_req !== e) begin
          errors++;
          $display("FAIL %s_sb: got %h expected %h", name, win_req, e);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (exp_ack[i]) begin
        e        = req[i];
        e.source = 4'(i);
        exp_q.push_back(e);
      end
    end
    tick();
  endtask

  initial begin
    tbl[0] = '{4'd1, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0};
    tbl[1] = '{4'd1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0};
    tbl[2] = '{4'd0, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0};
    tbl[3] = '{4'd3, 1'b1, 4'b0111, 4'b1000, 1'b0, 1'b0};
    tbl[4] = '{4'd2, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0};
    tbl[5] = '{4'd9, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0};
    tbl[6] = '{4'd9, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0};

    rst     = 1'b1;
    a_ready = 1'b1;
    d_valid = 1'b0;
    resp    = '0;
    c_ready = '0;
    for (int i = 0; i < N; i++) req[i] = '0;
    req[1] = mkreq(3'b000, 32'h0000_0100);

    // Reset state, with a pending request that must not be acknowledged.
    #2;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_wvalid", 32'(win_req.valid), 32'h0);
    check("rst_waddr", win_req.address, 32'h0);
    check("rst_src_err", 32'(src_err), 32'h0);
    check("rst_outst0", 32'(dut.outst_q[0]), 32'h0);
    req[1] = '0;
    tick();
    tick();
    rst = 1'b0;

    // Demux table; valid-source completions land on cores with outst=0.
    for (int k = 0; k < 7; k++) begin
      resp        = '0;
      resp.source = tbl[k].src;
      resp.data   = 32'hd000_0000 + 32'(k);
      d_valid     = tbl[k].dv;
      c_ready     = tbl[k].cr;
      #4;
      check($sformatf("dmx%0d_cvalid", k), 32'(c_valid), 32'(tbl[k].exp_cv));
      check($sformatf("dmx%0d_dready", k), 32'(d_ready), 32'(tbl[k].exp_dr));
      check($sformatf("dmx%0d_err", k), 32'(src_err), 32'(tbl[k].exp_err));
      check($sformatf("dmx%0d_cresp", k), c_resp[3].data, resp.data);
      tick();
    end
    d_valid = 1'b0;
    resp    = '0;
    c_ready = '0;
    check("underflow1", 32'(dut.outst_q[1]), 32'h0);
    check("underflow2", 32'(dut.outst_q[2]), 32'h0);
    step("err_hold_a", 4'b0000);
    check("err_sticky1", 32'(src_err), 32'h1);

    // Single request, source overwritten, capture one cycle later.
    a_ready = 1'b1;
    req[1]  = mkreq(3'b101, 32'h0000_1000);
    step("single", 4'b0010);
    req[1] = '0;
    check("single_wvalid", 32'(win_req.valid), 32'h1);
    check("single_src", 32'(win_req.source), 32'h1);
    check("single_op", 32'(win_req.opcode), 32'h5);
    step("single_pop", 4'b0000);
    check("single_clear", 32'(win_req.valid), 32'h0);

    // Backpressured response to core 1, then completion decrements outst.
    resp        = '0;
    resp.source = 4'd1;
    d_valid     = 1'b1;
    c_ready     = 4'b0000;
    #1;
    check("bp_dready", 32'(d_ready), 32'h0);
    check("bp_cvalid", 32'(c_valid), 32'h2);
    check("bp_outst_pre", 32'(dut.outst_q[1]), 32'h1);
    tick();
    c_ready = 4'b0010;
    #1;
    check("bp_dready_go", 32'(d_ready), 32'h1);
    tick();
    check("bp_outst_post", 32'(dut.outst_q[1]), 32'h0);
    d_valid = 1'b0;
    c_ready = '0;

    // Outstanding limit on core 2.
    req[2] = mkreq(3'b100, 32'h0000_2000);
    step("lim1", 4'b0100);
    step("lim2", 4'b0100);
    step("lim3", 4'b0000);
    step("lim4", 4'b0000);
    resp        = '0;
    resp.source = 4'd2;
    d_valid     = 1'b1;
    c_ready     = 4'b0100;
    step("lim_resp", 4'b0000);
    d_valid = 1'b0;
    step("lim_regrant", 4'b0100);
    req[2]  = '0;
    d_valid = 1'b1;
    step("lim_drain", 4'b0000);
    req[2] = mkreq(3'b100, 32'h0000_2400);
    step("lim_same", 4'b0100);
    req[2] = '0;
    check("same_cycle_outst", 32'(dut.outst_q[2]), 32'h1);
    step("lim_dec", 4'b0000);
    #1;
    check("stray_cvalid", 32'(c_valid), 32'h4);
    #1;
    step("lim_stray", 4'b0000);
    check("stray_outst", 32'(dut.outst_q[2]), 32'h0);
    d_valid = 1'b0;
    c_ready = '0;
    resp    = '0;

    // Aging while the output stage is blocked.
    a_ready = 1'b0;
    req[1]  = mkreq(3'b001, 32'h0000_3000);
    step("age_fill", 4'b0010);
    req[1] = '0;
    req[0] = mkreq(3'b010, 32'h0000_4000);
    req[3] = mkreq(3'b011, 32'h0000_7000);
    for (int c = 0; c < 5; c++) step("age_wait", 4'b0000);
    a_ready = 1'b1;
    #1;
    check("age3", 32'(dut.age_q[3]), 32'h5);
    check("age0", 32'(dut.age_q[0]), 32'h5);
    step("age_tie0", 4'b0001);
    req[0] = '0;
    req[2] = mkreq(3'b110, 32'h0000_6000);
    step("age_old3", 4'b1000);
    req[3] = '0;
    step("age_new2", 4'b0100);
    req[2] = '0;
    step("age_drain", 4'b0000);

    // Asynchronous reset with a request in flight and outst[0]=2.
    req[0] = mkreq(3'b000, 32'h0000_8000);
    step("rs_fill", 4'b0001);
    req[0]  = '0;
    a_ready = 1'b0;
    step("rs_hold", 4'b0000);
    check("rs_pre_valid", 32'(win_req.valid), 32'h1);
    check("rs_pre_outst", 32'(dut.outst_q[0]), 32'h2);
    check("err_sticky2", 32'(src_err), 32'h1);
    req[2]  = mkreq(3'b100, 32'h0000_9000);
    a_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", 32'(win_req.valid), 32'h0);
    check("rs_ack", 32'(ack), 32'h0);
    check("rs_outst", 32'(dut.outst_q[0]), 32'h0);
    check("rs_err", 32'(src_err), 32'h0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    step("rs_first", 4'b0100);
    req[2] = '0;
    check("rs_cap_valid", 32'(win_req.valid), 32'h1);
    check("rs_cap_src", 32'(win_req.source), 32'h2);
    step("rs_pop", 4'b0000);
    step("final", 4'b0000);
    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
